instr_stream_tx: RTL and testbench
==================================

// Module: instr_stream_tx
// PURPOSE
//  Instruction streamer (transmitter side) for the PE instruction decoder.
//  - On start, reads LEN words from instruction memory beginning at BASE.
//  - Memory read latency is fixed at 1 cycle.
//  - Buffers the words in a small prefetch FIFO.
//  - Presents the words in address order on a valid/ready link to the decoder in pru_sync.
//  - Pulses done when the last word has been accepted.
// PARAMETERS
//  INSTR_W   32  instruction word width (bits)
//  ADDR_W    12  instruction memory address width
//  FIFO_D    4   prefetch FIFO depth (power of 2, >=2)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse; sampled only in IDLE
//  base_addr    in   ADDR_W   first instruction address, latched on start
//  len          in   ADDR_W   number of words to send, latched on start
//  busy         out  1        high from accepted start until done
//  done         out  1        1-cycle pulse after last handshake
//  err_len0     out  1        1-cycle pulse: start with len==0
//  mem_rd_en    out  1        instruction memory read strobe
//  mem_rd_addr  out  ADDR_W   read address
//  mem_rd_data  in   INSTR_W  read data, valid exactly 1 cycle after mem_rd_en
//  instr_valid  out  1        word available to decoder
//  instr_data   out  INSTR_W  instruction word (FIFO head)
//  instr_ready  in   1        decoder accepts; transfer = valid & ready
// BEHAVIOUR
//  Reset values
//  - Reset clears all outputs: busy, done, err_len0, mem_rd_en, instr_valid are 0.
//  - Reset also zeroes mem_rd_addr and instr_data.
//  - Reset empties the FIFO, clears all counters and puts the FSM in IDLE.
//  - Reset asserted mid-stream aborts the stream immediately. No done pulse follows.
//  FSM IDLE -> FETCH -> DRAIN -> IDLE
//  - IDLE:
//    - start with len!=0: latch base/len, busy=1, go FETCH.
//    - start with len==0: pulse err_len0, stay IDLE, busy stays 0.
//  - FETCH:
//    - Issue a read when issued_cnt < len and (fifo_count + inflight) < FIFO_D.
//    - inflight is 0 or 1, because read latency is 1.
//    - mem_rd_addr = base + issued_cnt, wrapping modulo 2^ADDR_W.
//    - Go DRAIN in the cycle after the last read is issued.
//  - DRAIN:
//    - No reads are issued.
//    - When sent_cnt==len, go IDLE, pulse done, and drop busy in the same cycle.
//  - start received outside IDLE is ignored. No error is raised.
//  Datapath
//  - Read data is written into the FIFO in the cycle it returns. FIFO never overflows (credit rule above).
//  - instr_valid = FIFO not empty. instr_data = FIFO head, registered, with no bubble.
//  - While valid, instr_data must stay stable until it is accepted.
//  - Simultaneous FIFO push and pop are allowed, including when the FIFO is full. Count is unchanged.
//  - Latency from start to first instr_valid is 3 cycles:
//    - cycle 1: rd_en
//    - cycle 2: data written
//    - cycle 3: valid
//  - Steady-state throughput is 1 word/cycle while instr_ready is held high.
//  - Counters are ADDR_W+1 bits wide, so len = 2^ADDR_W-1 is the maximum and never overflows.
// TESTING
//  T1: base=0x010, len=5, ready=1 always.
//      -> Reads to 0x010..0x014 on consecutive cycles.
//      -> 5 transfers in order, first valid 3 cycles after start.
//      -> done pulses 1 cycle after the 5th transfer.
//  T2: len=10, ready=0 for 20 cycles, then ready=1.
//      -> Exactly 4 reads issued, then mem_rd_en stays 0.
//      -> instr_data holds word0 while stalled.
//      -> All 10 words arrive in order.
//  T3: base=0xFFE, len=4.
//      -> Read addresses 0xFFE, 0xFFF, 0x000, 0x001.
//  T4: start with len=0.
//      -> err_len0 pulses, busy stays 0, no reads issued.
//      -> A second start during busy does not perturb the stream.
//  T5: random ready pattern (50%), len=64, memory data = address.
//      -> Scoreboard sees 64 words, addresses in sequence, no loss and no duplicate.
//  T6: rst low after 3 transfers of len=8.
//      -> All outputs go 0 asynchronously, no done pulse.
//      -> A new start after reset behaves as in T1.

Source files
------------

// File: rtl/instr_stream_tx.sv
// Instruction streamer: fetches LEN words from instruction memory starting at BASE,
// buffers them in a small prefetch FIFO and presents them on a valid/ready link.
module instr_stream_tx #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 12,
  parameter int FIFO_D  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_base_addr,
  input  logic [ADDR_W-1:0]  i_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_len0,
  output logic               o_mem_rd_en,
  output logic [ADDR_W-1:0]  o_mem_rd_addr,
  input  logic [INSTR_W-1:0] i_mem_rd_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr_data,
  input  logic               i_instr_ready
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_issued;
  logic [LEN_W-1:0]   r_sent;
  logic               r_data_valid;
  logic [INSTR_W-1:0] r_fifo [FIFO_D];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_next;
  logic [CNT_W:0]     w_occupancy;
  logic               w_room;
  logic [LEN_W-1:0]   w_sent_next;
  logic [LEN_W-1:0]   w_issued_next;
  logic               w_issue_more;

  assign w_push        = r_data_valid;
  assign o_instr_valid = (r_count != '0);
  assign o_instr_data  = r_fifo[r_rptr];
  assign w_pop         = o_instr_valid & i_instr_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CNT_W'(1);
  end

  // Credit counts the post-edge FIFO fill plus the read whose data returns next cycle.
  assign w_occupancy   = {1'b0, w_count_next} + {{CNT_W{1'b0}}, o_mem_rd_en};
  assign w_room        = (w_occupancy < (CNT_W+1)'(FIFO_D));
  assign w_sent_next   = r_sent + {{ADDR_W{1'b0}}, w_pop};
  assign w_issued_next = r_issued + LEN_W'(1);
  assign w_issue_more  = (r_issued < r_len) && w_room;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_D; i++)
        r_fifo[i] <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= o_mem_rd_en;
      if (w_push) begin
        r_fifo[r_wptr] <= i_mem_rd_data;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_sent        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_len0    <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_mem_rd_addr <= '0;
    end else begin
      o_done      <= 1'b0;
      o_err_len0  <= 1'b0;
      o_mem_rd_en <= 1'b0;
      r_sent      <= w_sent_next;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              o_err_len0 <= 1'b1;
            end else begin
              // The first read goes out together with the start acceptance.
              r_base        <= i_base_addr;
              r_len         <= {1'b0, i_len};
              r_issued      <= LEN_W'(1);
              r_sent        <= '0;
              o_busy        <= 1'b1;
              o_mem_rd_en   <= 1'b1;
              o_mem_rd_addr <= i_base_addr;
              r_state       <= (i_len == ADDR_W'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (w_issue_more) begin
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= r_base + r_issued[ADDR_W-1:0];
            r_issued      <= w_issued_next;
            if (w_issued_next == r_len)
              r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_sent_next == r_len) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_tx.sv
// Self-checking bench for instr_stream_tx: cycle tables for the basic stream and
// zero-length start, plus hand-written stall, wrap, random-ready and reset sequences.
module tb_instr_stream_tx;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [11:0] baseAddr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        errLen0;
  logic        rdEn;
  logic [11:0] rdAddr;
  logic [31:0] memData = '0;
  logic        instrValid;
  logic [31:0] instrData;
  logic        ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic [11:0] base;
    logic [11:0] len;
    logic        ready;
    logic        expRdEn;
    logic [11:0] expAddr;
    logic        expValid;
    logic [31:0] expData;
    logic        expBusy;
    logic        expDone;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  instr_stream_tx #(.INSTR_W(32), .ADDR_W(12), .FIFO_D(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_start       (start),
    .i_base_addr   (baseAddr),
    .i_len         (len),
    .o_busy        (busy),
    .o_done        (done),
    .o_err_len0    (errLen0),
    .o_mem_rd_en   (rdEn),
    .o_mem_rd_addr (rdAddr),
    .i_mem_rd_data (memData),
    .o_instr_valid (instrValid),
    .o_instr_data  (instrData),
    .i_instr_ready (ready)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle latency, each word holds its own address.
  always @(posedge clk) begin
    if (rdEn)
      memData <= {20'b0, rdAddr};
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expWord(input logic [11:0] b, input int k);
    logic [11:0] a;
    a = b + k[11:0];
    return {20'b0, a};
  endfunction

  task automatic addVec(input logic st, input logic [11:0] b, input logic [11:0] n,
                        input logic rdy, input logic eRd, input logic [11:0] eAddr,
                        input logic eVal, input logic [31:0] eData, input logic eBusy,
                        input logic eDone, input logic eErr);
    vec_t v;
    v.start = st;  v.base = b;  v.len = n;  v.ready = rdy;
    v.expRdEn = eRd;  v.expAddr = eAddr;  v.expValid = eVal;  v.expData = eData;
    v.expBusy = eBusy;  v.expDone = eDone;  v.expErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.start;
    baseAddr = v.base;
    len      = v.len;
    ready    = v.ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("row%0d.rdEn", idx), {31'b0, rdEn}, {31'b0, v.expRdEn});
    if (v.expRdEn)
      checkValue($sformatf("row%0d.rdAddr", idx), {20'b0, rdAddr}, {20'b0, v.expAddr});
    checkValue($sformatf("row%0d.valid", idx), {31'b0, instrValid}, {31'b0, v.expValid});
    if (v.expValid)
      checkValue($sformatf("row%0d.data", idx), instrData, v.expData);
    checkValue($sformatf("row%0d.busy", idx), {31'b0, busy}, {31'b0, v.expBusy});
    checkValue($sformatf("row%0d.done", idx), {31'b0, done}, {31'b0, v.expDone});
    checkValue($sformatf("row%0d.err", idx), {31'b0, errLen0}, {31'b0, v.expErr});
  endtask

  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one stream to completion, checking read addresses, word order and the done pulse.
  task automatic runStream(input logic [11:0] b, input logic [11:0] n, input int stallCycles,
                           input bit randomReady, input int extraStartCycle, input string tag);
    int reads = 0, words = 0, dones = 0, errs = 0, cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;  baseAddr = b;  len = n;
    ready = (stallCycles == 0) && !randomReady;
    @(posedge clk); #1;
    start = 1'b0;
    while (dones == 0 && cyc < 2000) begin
      cyc++;
      if (cyc == extraStartCycle) begin
        start = 1'b1;  baseAddr = b + 12'h100;  len = 12'd3;
      end else begin
        start = 1'b0;
      end
      if (cyc <= stallCycles)
        ready = 1'b0;
      else if (randomReady)
        ready = 1'($urandom_range(0, 1));
      else
        ready = 1'b1;
      @(negedge clk);
      if (rdEn) begin
        checkValue({tag, ".rdAddr"}, {20'b0, rdAddr}, expWord(b, reads));
        reads++;
      end
      if (cyc <= stallCycles && instrValid)
        checkValue({tag, ".stallHead"}, instrData, expWord(b, 0));
      if (cyc == stallCycles && stallCycles > 0)
        checkValue({tag, ".stallReads"}, reads, 4);
      if (instrValid && ready) begin
        checkValue({tag, ".word"}, instrData, expWord(b, words));
        words++;
      end
      if (errLen0)
        errs++;
      if (done) begin
        dones++;
        checkValue({tag, ".busyAtDone"}, {31'b0, busy}, 32'd0);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkValue({tag, ".doneSeen"}, dones, 1);
    checkValue({tag, ".words"}, words, 32'(n));
    checkValue({tag, ".reads"}, reads, 32'(n));
    checkValue({tag, ".errs"}, errs, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, ".busy"}, {31'b0, busy}, 32'd0);
    checkValue({tag, ".done"}, {31'b0, done}, 32'd0);
    checkValue({tag, ".err"}, {31'b0, errLen0}, 32'd0);
    checkValue({tag, ".rdEn"}, {31'b0, rdEn}, 32'd0);
    checkValue({tag, ".rdAddr"}, {20'b0, rdAddr}, 32'd0);
    checkValue({tag, ".valid"}, {31'b0, instrValid}, 32'd0);
    checkValue({tag, ".data"}, instrData, 32'd0);
  endtask

  // Abort a len=8 stream after three transfers and confirm nothing survives the reset.
  task automatic runResetAbort();
    int words = 0, cyc = 0, dones = 0;
    @(posedge clk); #1;
    start = 1'b1;  baseAddr = 12'h020;  len = 12'd8;  ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (words < 3 && cyc < 50) begin
      cyc++;
      @(negedge clk);
      if (instrValid && ready)
        words++;
      if (words < 3) begin
        @(posedge clk); #1;
      end
    end
    checkValue("abort.preWords", words, 3);
    @(posedge clk); #2;
    rstN = 1'b0;
    #1;
    checkAllZero("abort");
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done)
        dones++;
    end
    checkValue("abort.noDone", dones, 0);
    checkValue("abort.idleBusy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rstN = 1'b0;  start = 1'b0;  baseAddr = '0;  len = '0;  ready = 1'b0;

    // Basic stream: base 0x010, len 5, ready always high (rows 0..9).
    addVec(1, 12'h010, 12'd5, 1, 0, 12'h000, 0, 32'h0,   0, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 1, 12'h010, 0, 32'h0,   1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 1, 12'h011, 0, 32'h0,   1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 1, 12'h012, 1, 32'h010, 1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 1, 12'h013, 1, 32'h011, 1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 1, 12'h014, 1, 32'h012, 1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 0, 12'h000, 1, 32'h013, 1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 0, 12'h000, 1, 32'h014, 1, 0, 0);
    addVec(0, 12'h010, 12'd5, 1, 0, 12'h000, 0, 32'h0,   0, 1, 0);
    addVec(0, 12'h010, 12'd5, 1, 0, 12'h000, 0, 32'h0,   0, 0, 0);
    // Zero-length start (rows 10..12).
    addVec(1, 12'h300, 12'd0, 1, 0, 12'h000, 0, 32'h0,   0, 0, 0);
    addVec(0, 12'h300, 12'd0, 1, 0, 12'h000, 0, 32'h0,   0, 0, 1);
    addVec(0, 12'h300, 12'd0, 1, 0, 12'h000, 0, 32'h0,   0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    runTable(0, 9);
    runTable(10, 12);
    runStream(12'h040, 12'd10, 20, 1'b0, 0, "stall");
    runStream(12'hFFE, 12'd4,  0,  1'b0, 0, "wrap");
    runStream(12'h200, 12'd6,  0,  1'b0, 3, "restart");
    runStream(12'h080, 12'd64, 0,  1'b1, 0, "random");
    runResetAbort();
    runTable(0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
